// File: rtl/ntt_io_ctrl.sv
`timescale 1ns/1ps
// Streaming I/O controller around the NTT core: loads N coefficients into banked memory, kicks the core, streams results out.
// Load writes land 1 cycle after each handshake; unload reads run 2 cycles ahead of m_valid and stall cleanly on m_ready.
module ntt_io_ctrl #(
    parameter int DATA_W = 32,
    parameter int N      = 1024,
    parameter int BANKS  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              start,
    input  logic              ntt_finished,
    output logic              mem_sel,
    output logic              ld_wen,
    output logic [3:0]        ld_bank,
    output logic [8:0]        ld_addr,
    output logic [DATA_W-1:0] ld_wdata,
    output logic              ul_ren,
    output logic [3:0]        ul_bank,
    output logic [8:0]        ul_addr,
    input  logic [DATA_W-1:0] ul_rdata,
    output logic              busy,
    output logic              done
);

    localparam int         BW   = $clog2(BANKS);
    localparam logic [9:0] LAST = 10'(N - 1);

    typedef enum logic [1:0] {S_LOAD, S_KICK, S_RUN, S_UNLOAD} state_t;

    state_t            state_q;
    logic [9:0]        ld_cnt_q;
    logic [9:0]        rd_cnt_q;
    logic [9:0]        wr_cnt_q;
    logic              rd_cnt_done_q;
    logic              inflight_q;
    logic              ld_wen_q;
    logic              start_q;
    logic              done_q;
    logic [3:0]        ld_bank_q;
    logic [8:0]        ld_addr_q;
    logic [DATA_W-1:0] ld_wdata_q;

    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        fifo_wptr_q;
    logic [1:0]        fifo_rptr_q;
    logic [2:0]        fifo_cnt_q;
    logic [2:0]        fifo_cnt_d;

    logic              s_hs;
    logic              m_hs;
    logic              fifo_push;

    assign s_ready   = (state_q == S_LOAD);
    assign mem_sel   = (state_q != S_RUN);
    assign busy      = (state_q != S_LOAD) || (ld_cnt_q != 10'd0);
    assign m_valid   = (fifo_cnt_q != 3'd0);
    assign m_data    = fifo_mem[fifo_rptr_q];
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign fifo_push = inflight_q;

    assign start     = start_q;
    assign done      = done_q;
    assign ld_wen    = ld_wen_q;
    assign ld_bank   = ld_bank_q;
    assign ld_addr   = ld_addr_q;
    assign ld_wdata  = ld_wdata_q;

    // Reads in flight count against FIFO space so a stalled output can never overflow the 4 entries.
    assign ul_ren  = (state_q == S_UNLOAD) && !rd_cnt_done_q &&
                     ((fifo_cnt_q + {2'b00, inflight_q}) < 3'd3);
    assign ul_bank = rd_cnt_q[BW-1:0];
    assign ul_addr = (state_q == S_UNLOAD) ? {3'b100, rd_cnt_q[9:BW]} : 9'd0;

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({fifo_push, m_hs})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 3'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 3'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wptr_q] <= ul_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_LOAD;
            ld_cnt_q      <= 10'd0;
            rd_cnt_q      <= 10'd0;
            wr_cnt_q      <= 10'd0;
            rd_cnt_done_q <= 1'b0;
            inflight_q    <= 1'b0;
            ld_wen_q      <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            ld_bank_q     <= 4'd0;
            ld_addr_q     <= 9'd0;
            ld_wdata_q    <= '0;
            fifo_wptr_q   <= 2'd0;
            fifo_rptr_q   <= 2'd0;
            fifo_cnt_q    <= 3'd0;
        end else begin
            ld_wen_q   <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= ul_ren;
            fifo_cnt_q <= fifo_cnt_d;
            if (fifo_push) begin
                fifo_wptr_q <= fifo_wptr_q + 2'd1;
            end
            if (m_hs) begin
                fifo_rptr_q <= fifo_rptr_q + 2'd1;
            end
            case (state_q)
                S_LOAD: begin
                    if (s_hs) begin
                        ld_wen_q   <= 1'b1;
                        ld_bank_q  <= ld_cnt_q[BW-1:0];
                        ld_addr_q  <= {3'b000, ld_cnt_q[9:BW]};
                        ld_wdata_q <= s_data;
                        ld_cnt_q   <= ld_cnt_q + 10'd1;
                        if (ld_cnt_q == LAST) begin
                            state_q <= S_KICK;
                            start_q <= 1'b1;
                        end
                    end
                end
                S_KICK: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (ntt_finished) begin
                        state_q <= S_UNLOAD;
                    end
                end
                S_UNLOAD: begin
                    if (ul_ren) begin
                        rd_cnt_q <= rd_cnt_q + 10'd1;
                        if (rd_cnt_q == LAST) begin
                            rd_cnt_done_q <= 1'b1;
                        end
                    end
                    if (m_hs) begin
                        wr_cnt_q <= wr_cnt_q + 10'd1;
                        if (wr_cnt_q == LAST) begin
                            state_q       <= S_LOAD;
                            done_q        <= 1'b1;
                            rd_cnt_done_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/ntt_io_ctrl.md
# ntt_io_ctrl

Streaming I/O controller wrapped around the 1024-point NTT core. It accepts 1024 input coefficients on a valid/ready stream and writes them into the 16-bank coefficient memory. It then pulses `start` to the NTT address generator and waits for `ntt_finished`. Finally it reads the transformed coefficients back from the memory and streams them out in natural index order with full backpressure support.

## Interface
Parameters:
- `DATA_W`, default 32: coefficient width.
- `N`, default 1024: transform length. Fixed; the counters are 10-bit.
- `BANKS`, default 16: number of memory banks (`N/BANKS` = 64 words per bank per region).

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `s_valid`  in  1: input coefficient valid.
- `s_ready`  out  1: input accept.
- `s_data`  in  DATA_W: input coefficient, index order 0..N-1.
- `m_valid`  out  1: output coefficient valid.
- `m_ready`  in  1: output accept.
- `m_data`  out  DATA_W: output coefficient, index order 0..N-1.
- `start`  out  1: one-cycle pulse to the address generator.
- `ntt_finished`  in  1: completion pulse from the address generator.
- `mem_sel`  out  1: memory ownership. 1 = this block owns the memory ports; 0 = the NTT datapath owns them.
- `ld_wen`  out  1: load write enable.
- `ld_bank`  out  4: load bank select.
- `ld_addr`  out  9: load word address.
- `ld_wdata`  out  DATA_W: load write data.
- `ul_ren`  out  1: unload read enable.
- `ul_bank`  out  4: unload bank select.
- `ul_addr`  out  9: unload word address.
- `ul_rdata`  in  DATA_W: unload read data, valid 1 cycle after `ul_ren`.
- `busy`  out  1: high whenever the state is not LOAD, or `ld_cnt` != 0.
- `done`  out  1: one-cycle pulse after the last output beat.

## Operation
- States: LOAD (reset state), KICK, RUN, UNLOAD.
- **LOAD**
  - `s_ready`=1.
  - Each handshake (`s_valid` & `s_ready`) increments the 10-bit `ld_cnt`.
  - Each handshake registers one write with bank = `ld_cnt[3:0]` and addr = {2'b00, 1'b0, `ld_cnt[9:4]`}.
  - On the handshake with `ld_cnt`==1023 the block goes to KICK, and `ld_cnt` wraps to 0.
- **KICK**
  - `start`=1 for exactly this one cycle, then the block goes to RUN.
  - `s_ready`=0.
- **RUN**
  - `mem_sel`=0. `ld_wen` and `ul_ren` are held at 0.
  - On `ntt_finished`=1 the block goes to UNLOAD.
- **UNLOAD**
  - Results are read from region 2'b10: addr = {2'b10, 1'b0, `rd_cnt[9:4]`}, bank = `rd_cnt[3:0]`.
  - `ul_ren` is combinational: `ul_ren` = (`rd_cnt_done`==0) & (`fifo_cnt` + `inflight` < 3).
  - `inflight` is a 1-bit register equal to the previous cycle's `ul_ren`.
  - `ul_rdata` is pushed into a 4-entry FIFO the cycle after `ul_ren`.
  - `m_valid` = FIFO non-empty. `m_data` = FIFO head.
  - Output handshakes increment `wr_cnt`. On the handshake with `wr_cnt`==1023 the block goes to LOAD and pulses `done` in the following cycle.
- `mem_sel`=1 in LOAD, KICK and UNLOAD.
- `ntt_finished` outside RUN is ignored. `s_valid` outside LOAD is ignored.
- A FIFO push and pop in the same cycle leaves `fifo_cnt` unchanged. The FIFO can never overflow under the issue rule.

## Timing
- Reset values (asynchronous):
  - state LOAD.
  - All counters 0. FIFO empty. `inflight` 0.
  - `s_ready`=1, `m_valid`=0, `start`=0, `mem_sel`=1, `ld_wen`=0, `ul_ren`=0, `busy`=0, `done`=0.
  - `ld_bank`/`ld_addr`/`ld_wdata`/`ul_bank`/`ul_addr`=0.
- Reset asserted mid-operation aborts everything immediately. No `start` or `done` is produced. The FIFO contents are discarded.
- Load write latency: the handshake in cycle t gives `ld_wen`=1 in cycle t+1. The 1024th write therefore occurs during KICK, while `mem_sel` is still 1.
- `s_ready` is 0 from the cycle after the 1024th handshake.
- `start` is asserted the cycle after the 1024th handshake. `mem_sel` falls the following cycle.
- UNLOAD read-to-output latency:
  - The state becomes UNLOAD at edge e. The first `ul_ren` is in cycle e, and the first `m_valid` is in cycle e+2.
  - With `m_ready` held at 1, throughput is one beat per cycle.
  - The last beat occurs at e+1025. `done` is in cycle e+1026, and `s_ready`=1 from cycle e+1026.
- Under backpressure, `m_valid` and `m_data` stay stable until accepted.

## Test plan
- Reset, then stream 1024 beats with `s_data`=i, `s_valid` always 1:
  - `ld_wen` in 1024 consecutive cycles.
  - Beat 17 writes bank 1, addr 0x001. Beat 1023 writes bank 15, addr 0x03F.
  - Single `start` pulse; `mem_sel` falls.
- Gaps on `s_valid` (random 50 %) during load: still exactly 1024 writes, with no duplicate or skipped index; `start` only after the 1024th beat.
- In RUN, drive `ntt_finished` after 200 cycles with memory model region 2 word[k]=k^0x5A5A:
  - `m_data` sequence equals k^0x5A5A for k=0..1023.
  - First `m_valid` 2 cycles after UNLOAD entry; `done` one cycle after the last beat.
- Random `m_ready` (30 % high) during unload: no loss or duplication, `m_data` held stable while stalled, FIFO never exceeds 4 entries.
- `ntt_finished` pulsed during LOAD and during KICK: ignored; the state machine does not advance early.
- Assert `reset` at output beat 500 of UNLOAD: all outputs return to reset values asynchronously, and a subsequent full load/run/unload completes correctly.
